bcd_arbiter: RTL

BCD_ARBITER -- requirements
Module: bcd_arbiter

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_step.sv | 26 ++
 rtl/bcd_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] CORR_THRESH = 4'd4;
    localparam logic [3:0] CORR_ADD    = 4'd3;

    function automatic logic [DIGIT_W-1:0] bcd_correct(
        input logic [DIGIT_W-1:0] d
    );
        return (d > CORR_THRESH) ? d + CORR_ADD : d;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// One combinational double-dabble step: correct both digits, then shift left.
module bcd_step
    import bcd_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [DIGIT_W-1:0] tens_i,
    input  logic [DIGIT_W-1:0] ones_i,
    input  logic [WIDTH-1:0]   bin_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o,
    output logic [WIDTH-1:0]   bin_o
);

    logic [DIGIT_W-1:0] tens_c;
    logic [DIGIT_W-1:0] ones_c;

    always_comb begin
        tens_c = bcd_correct(tens_i);
        ones_c = bcd_correct(ones_i);
        tens_o = {tens_c[DIGIT_W-2:0], ones_c[DIGIT_W-1]};
        ones_o = {ones_c[DIGIT_W-2:0], bin_i[WIDTH-1]};
        bin_o  = bin_i << 1;
    end

endmodule

// File: rtl/bcd_arbiter.sv
// Two-requester round-robin front end sharing one sequential
// binary-to-BCD converter.
module bcd_arbiter
    import bcd_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [DIGIT_W-1:0] acc_tens_q, acc_tens_d;
    logic [DIGIT_W-1:0] acc_ones_q, acc_ones_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;

    logic [DIGIT_W-1:0] step_tens;
    logic [DIGIT_W-1:0] step_ones;
    logic [WIDTH-1:0]   step_bin;

    bcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .tens_i (acc_tens_q),
        .ones_i (acc_ones_q),
        .bin_i  (bin_q),
        .tens_o (step_tens),
        .ones_o (step_ones),
        .bin_o  (step_bin)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        bin_d      = bin_q;
        acc_tens_d = acc_tens_q;
        acc_ones_d = acc_ones_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever was not served last
                    gnt_d      = (req0 && req1) ? ~last_q : req1;
                    bin_d      = gnt_d ? data1 : data0;
                    acc_tens_d = '0;
                    acc_ones_d = '0;
                    cnt_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_tens_d = step_tens;
                acc_ones_d = step_ones;
                bin_d      = step_bin;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    ones_d  = step_ones;
                    tens_d  = step_tens;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            bin_q      <= '0;
            acc_tens_q <= '0;
            acc_ones_q <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            tens_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            bin_q      <= bin_d;
            acc_tens_q <= acc_tens_d;
            acc_ones_q <= acc_ones_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
        end
    end

    assign ack0 = (state_q == DONE) && !gnt_q;
    assign ack1 = (state_q == DONE) && gnt_q;
    assign busy = (state_q != IDLE);
    assign ones = ones_q;
    assign tens = tens_q;

endmodule
